// File: rtl/memory_arbiter.sv
// Shared-RAM arbiter for the icache and dcache: dcache priority, bounded dcache streak,
// one transaction per grant, and a mandatory IDLE cycle between grants.
module memory_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        busy,
   output logic [7:0]  err_cnt
);

   localparam int STREAK_W = $clog2(STARVE_MAX + 1);
   localparam logic [1:0] RAM_ACCESS = 2'b10;
   localparam logic [1:0] RAM_ERROR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      IGNT = 2'b01,
      DGNT = 2'b10
   } state_t;

   state_t              state_r;
   logic [STREAK_W-1:0] streak_r;
   logic [7:0]          err_cnt_r;

   logic dreq_s;
   logic access_s;
   logic error_s;
   logic streak_full_s;
   logic grant_i_s;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] v);
      return (v == STREAK_W'(STARVE_MAX)) ? v : v + STREAK_W'(1);
   endfunction

   assign dreq_s        = dREN | dWEN;
   assign access_s      = (ramstate == RAM_ACCESS);
   assign error_s       = (ramstate == RAM_ERROR);
   assign streak_full_s = (streak_r == STREAK_W'(STARVE_MAX));
   // icache wins when alone, or when the dcache has used up its streak
   assign grant_i_s     = iREN & (~dreq_s | streak_full_s);

   // Arbitration state, starvation streak and error counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r   <= IDLE;
         streak_r  <= {STREAK_W{1'b0}};
         err_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_i_s) begin
                  state_r  <= IGNT;
                  streak_r <= {STREAK_W{1'b0}};
               end else if (dreq_s) begin
                  state_r  <= DGNT;
                  streak_r <= iREN ? streak_inc(streak_r) : {STREAK_W{1'b0}};
               end else begin
                  state_r <= IDLE;
               end
            end
            IGNT: begin
               if (error_s) begin
                  err_cnt_r <= sat_inc8(err_cnt_r);
               end
               if (access_s || !iREN) begin
                  state_r <= IDLE;
               end
            end
            DGNT: begin
               if (error_s) begin
                  err_cnt_r <= sat_inc8(err_cnt_r);
               end
               if (access_s || !dreq_s) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // RAM port and requester responses follow the live signals of the granted side
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = 32'd0;
      dload    = 32'd0;
      case (state_r)
         IDLE: begin
            ramREN = 1'b0;
         end
         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iload   = ramload;
            iwait   = ~access_s;
         end
         DGNT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dload    = ramload;
            dwait    = ~access_s;
         end
         default: begin
            ramREN = 1'b0;
         end
      endcase
   end

   assign busy    = (state_r != IDLE);
   assign err_cnt = err_cnt_r;

   memory_arbiter_checker u_checker (
      .CLK    (CLK),
      .nRST   (nRST),
      .ramREN (ramREN),
      .ramWEN (ramWEN),
      .busy   (busy),
      .iwait  (iwait),
      .dwait  (dwait)
   );

endmodule

// Structural invariants of the arbiter outputs.
module memory_arbiter_checker (
   input logic CLK,
   input logic nRST,
   input logic ramREN,
   input logic ramWEN,
   input logic busy,
   input logic iwait,
   input logic dwait
);

   a_no_rw_overlap: assert property (@(posedge CLK) disable iff (!nRST) !(ramREN && ramWEN))
      else $error("arbiter: RAM read and write enables both high");

   a_idle_quiet: assert property (@(posedge CLK) disable iff (!nRST) !busy |-> (!ramREN && !ramWEN))
      else $error("arbiter: RAM enabled while idle");

   a_one_completion: assert property (@(posedge CLK) disable iff (!nRST) (iwait || dwait))
      else $error("arbiter: both requesters released in the same cycle");

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a completion scoreboard.
module tb_memory_arbiter;

   localparam logic [1:0] FREE   = 2'b00;
   localparam logic [1:0] BUSYS  = 2'b01;
   localparam logic [1:0] ACCESS = 2'b10;
   localparam logic [1:0] ERROR  = 2'b11;
   localparam logic [31:0] KEY   = 32'h5A5A_0000;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore;
   logic        iwait, dwait;
   logic [31:0] iload, dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;
   logic        busy;
   logic [7:0]  err_cnt;

   logic        use_model;
   logic [31:0] ramload_v;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   // RAM read data: either a fixed value or an address-derived pattern
   assign ramload = use_model ? (ramaddr ^ KEY) : ramload_v;

   memory_arbiter #(.STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate),
      .busy(busy), .err_cnt(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   // Completion monitor: every released wait must match the oldest expected transaction
   always @(negedge CLK) begin
      exp_t e;
      if (nRST && (!iwait || !dwait)) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("done_port", {31'd0, ~dwait}, {31'd0, e.is_d});
            chk("done_data", e.is_d ? dload : iload, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
      ramstate = FREE; use_model = 1'b0; ramload_v = 32'd0;

      smp();
      chk("rst_iwait",   {31'd0, iwait},  32'd1);
      chk("rst_dwait",   {31'd0, dwait},  32'd1);
      chk("rst_ramREN",  {31'd0, ramREN}, 32'd0);
      chk("rst_ramWEN",  {31'd0, ramWEN}, 32'd0);
      chk("rst_ramaddr", ramaddr,         32'd0);
      chk("rst_busy",    {31'd0, busy},   32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      nxt();
      nRST = 1'b1;

      // single fetch, ACCESS on the second grant cycle
      iREN = 1'b1; iaddr = 32'h40; ramstate = BUSYS; ramload_v = 32'hDEADBEEF;
      sb_q.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
      smp();
      chk("f_idle_busy", {31'd0, busy}, 32'd0);
      nxt();
      smp();
      chk("f_gnt_busy",   {31'd0, busy},   32'd1);
      chk("f_gnt_ramREN", {31'd0, ramREN}, 32'd1);
      chk("f_gnt_addr",   ramaddr,         32'h40);
      chk("f_gnt_iwait",  {31'd0, iwait},  32'd1);
      nxt();
      ramstate = ACCESS;
      smp();
      chk("f_acc_iwait", {31'd0, iwait}, 32'd0);
      chk("f_acc_iload", iload,          32'hDEADBEEF);
      nxt();
      iREN = 1'b0; ramstate = FREE;
      smp();
      chk("f_end_busy",  {31'd0, busy},  32'd0);
      chk("f_end_iwait", {31'd0, iwait}, 32'd1);
      chk("f_end_iload", iload,          32'd0);
      nxt();

      // simultaneous requests: dcache write first, then the fetch
      iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
      ramload_v = 32'd0;
      sb_q.push_back('{is_d: 1'b1, data: 32'd0});
      sb_q.push_back('{is_d: 1'b0, data: 32'hCAFEF00D});
      nxt();
      ramstate = ACCESS;
      smp();
      chk("s_ramWEN",   {31'd0, ramWEN}, 32'd1);
      chk("s_ramREN",   {31'd0, ramREN}, 32'd0);
      chk("s_ramaddr",  ramaddr,         32'h80);
      chk("s_ramstore", ramstore,        32'h12345678);
      chk("s_iwait",    {31'd0, iwait},  32'd1);
      nxt();
      dWEN = 1'b0; ramload_v = 32'hCAFEF00D;
      smp();
      chk("s_mid_busy", {31'd0, busy}, 32'd0);
      nxt();
      smp();
      chk("s_i_ramREN", {31'd0, ramREN}, 32'd1);
      chk("s_i_addr",   ramaddr,         32'h44);
      nxt();
      iREN = 1'b0; ramstate = FREE;
      nxt();

      // starvation bound: D,D,D,D,I,D with immediate ACCESS
      use_model = 1'b1;
      iREN = 1'b1; iaddr = 32'h100; dREN = 1'b1; daddr = 32'h200; ramstate = ACCESS;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) sb_q.push_back('{is_d: 1'b0, data: 32'h100 ^ KEY});
         else        sb_q.push_back('{is_d: 1'b1, data: 32'h200 ^ KEY});
      end
      for (int c = 0; c < 40; c++) begin
         nxt();
         if (sb_q.size() == 0) break;
      end
      iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
      chk("starve_drained", 32'(sb_q.size()), 32'd0);
      nxt();

      // error retry on a dcache read
      dREN = 1'b1; daddr = 32'h300;
      sb_q.push_back('{is_d: 1'b1, data: 32'h300 ^ KEY});
      nxt();
      ramstate = ERROR;
      for (int e = 0; e < 3; e++) begin
         smp();
         chk("e_dwait_hi", {31'd0, dwait}, 32'd1);
         nxt();
      end
      ramstate = ACCESS;
      smp();
      chk("e_err_cnt", {24'd0, err_cnt}, 32'd3);
      chk("e_dwait_lo", {31'd0, dwait}, 32'd0);
      nxt();
      dREN = 1'b0; ramstate = FREE;
      smp();
      chk("e_end_dwait", {31'd0, dwait}, 32'd1);
      chk("e_end_busy",  {31'd0, busy},  32'd0);
      nxt();

      // abort: dREN dropped while granted
      dREN = 1'b1; daddr = 32'h400; ramstate = BUSYS;
      nxt();
      smp();
      chk("a_gnt_busy",  {31'd0, busy},   32'd1);
      chk("a_gnt_ramREN", {31'd0, ramREN}, 32'd1);
      nxt();
      dREN = 1'b0;
      nxt();
      smp();
      chk("a_idle_busy", {31'd0, busy}, 32'd0);
      nxt();

      // asynchronous reset while in IGNT
      iREN = 1'b1; iaddr = 32'h500; ramstate = BUSYS;
      nxt();
      smp();
      chk("r_gnt_ramREN", {31'd0, ramREN}, 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      chk("r_busy",    {31'd0, busy},    32'd0);
      chk("r_ramREN",  {31'd0, ramREN},  32'd0);
      chk("r_ramaddr", ramaddr,          32'd0);
      chk("r_iwait",   {31'd0, iwait},   32'd1);
      chk("r_err_cnt", {24'd0, err_cnt}, 32'd0);
      nxt();
      iREN = 1'b0; ramstate = FREE; nRST = 1'b1;
      nxt();

      chk("sb_final_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
